// File: rtl/fan_state_ctrl.sv
// Fan controller: OFF/LOW/MID/HIGH speed FSM with a stepped auto-off timer
// and a free-running PWM whose duty follows the current speed.
module fan_state_ctrl #(
  parameter int TICK_CYCLES = 100000000,
  parameter int PWM_PERIOD  = 100,
  parameter int DUTY_LOW    = 30,
  parameter int DUTY_MID    = 60,
  parameter int DUTY_HIGH   = 90,
  parameter int TIMER_STEP  = 30
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_power,
  input  logic       i_btn_speed,
  input  logic       i_btn_timer,
  output logic [2:0] o_fanState,
  output logic       o_pwm,
  output logic       o_timer_active,
  output logic [6:0] o_timer_remain
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int PWM_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_CYCLES - 1);
  localparam logic [PWM_W-1:0] PWM_LAST   = PWM_W'(PWM_PERIOD - 1);
  localparam logic [7:0]       STEP       = 8'(TIMER_STEP);
  localparam logic [7:0]       REMAIN_MAX = 8'(3 * TIMER_STEP);

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    LOW  = 3'd1,
    MID  = 3'd2,
    HIGH = 3'd3
  } fan_state_t;

  fan_state_t       state, state_next;
  logic [6:0]       remain, remain_next;
  logic             active, active_next;
  logic [PRE_W-1:0] prescale, prescale_next;
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W:0]   duty;
  logic [7:0]       stepped;
  logic             tick;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= OFF;
      remain   <= '0;
      active   <= 1'b0;
      prescale <= '0;
    end else begin
      state    <= state_next;
      remain   <= remain_next;
      active   <= active_next;
      prescale <= prescale_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      pwm_cnt <= '0;
    else if (pwm_cnt == PWM_LAST)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Power beats expiry, expiry beats speed/timer presses; a timer press
  // restarts the prescaler and swallows a coincident non-expiry tick.
  always_comb begin
    tick          = active && (prescale == PRE_LAST);
    stepped       = {1'b0, remain} + STEP;
    state_next    = state;
    remain_next   = remain;
    active_next   = active;
    prescale_next = active ? prescale + 1'b1 : '0;
    if (tick)
      prescale_next = '0;

    if (i_btn_power) begin
      if (state == OFF) begin
        state_next = LOW;
      end else begin
        state_next    = OFF;
        remain_next   = '0;
        active_next   = 1'b0;
        prescale_next = '0;
      end
    end else if (tick && remain == 7'd1) begin
      state_next    = OFF;
      remain_next   = '0;
      active_next   = 1'b0;
      prescale_next = '0;
    end else if (state != OFF) begin
      if (i_btn_speed) begin
        case (state)
          LOW:     state_next = MID;
          MID:     state_next = HIGH;
          default: state_next = LOW;
        endcase
      end
      if (i_btn_timer) begin
        if (stepped > REMAIN_MAX) begin
          remain_next = '0;
          active_next = 1'b0;
        end else begin
          remain_next = stepped[6:0];
          active_next = (stepped != 8'd0);
        end
        prescale_next = '0;
      end else if (tick) begin
        remain_next = remain - 7'd1;
      end
    end
  end

  always_comb begin
    case (state)
      LOW:     duty = (PWM_W+1)'(DUTY_LOW);
      MID:     duty = (PWM_W+1)'(DUTY_MID);
      HIGH:    duty = (PWM_W+1)'(DUTY_HIGH);
      default: duty = '0;
    endcase
  end

  assign o_pwm          = ({1'b0, pwm_cnt} < duty);
  assign o_fanState     = state;
  assign o_timer_active = active;
  assign o_timer_remain = remain;

endmodule

// File: tb/tb_fan_state_ctrl.sv
// Self-checking bench for fan_state_ctrl: directed scenarios plus random
// button traffic compared against a cycle-level behavioural model.
module tb_fan_state_ctrl;

  logic       i_clk;
  logic       i_reset;
  logic       i_btn_power;
  logic       i_btn_speed;
  logic       i_btn_timer;
  logic [2:0] o_fanState;
  logic       o_pwm;
  logic       o_timer_active;
  logic [6:0] o_timer_remain;

  int total;
  int bad;

  // Model: speed level, seconds left, cycles until next tick, PWM position.
  int m_level;
  int m_remain;
  int m_cyc_left;
  int m_pwm_pos;
  int duty_tab[4] = '{0, 3, 6, 9};

  fan_state_ctrl #(
    .TICK_CYCLES(10),
    .PWM_PERIOD (10),
    .DUTY_LOW   (3),
    .DUTY_MID   (6),
    .DUTY_HIGH  (9),
    .TIMER_STEP (2)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_btn_power   (i_btn_power),
    .i_btn_speed   (i_btn_speed),
    .i_btn_timer   (i_btn_timer),
    .o_fanState    (o_fanState),
    .o_pwm         (o_pwm),
    .o_timer_active(o_timer_active),
    .o_timer_remain(o_timer_remain)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_level    = 0;
    m_remain   = 0;
    m_cyc_left = 10;
    m_pwm_pos  = 0;
  endtask

  task automatic model_update(input logic p, input logic s, input logic t);
    bit tick;
    tick = 0;
    if (m_remain != 0) begin
      m_cyc_left--;
      if (m_cyc_left == 0) tick = 1;
    end
    if (p) begin
      if (m_level == 0) m_level = 1;
      else begin
        m_level  = 0;
        m_remain = 0;
      end
    end else if (tick && m_remain == 1) begin
      m_level  = 0;
      m_remain = 0;
    end else if (m_level != 0) begin
      if (s) m_level = (m_level == 3) ? 1 : m_level + 1;
      if (t) begin
        m_remain   = (m_remain + 2 > 6) ? 0 : m_remain + 2;
        m_cyc_left = 10;
      end else if (tick) begin
        m_remain   = m_remain - 1;
        m_cyc_left = 10;
      end
    end
    m_pwm_pos = (m_pwm_pos + 1) % 10;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive_cycle(input logic p, input logic s, input logic t);
    i_btn_power = p;
    i_btn_speed = s;
    i_btn_timer = t;
    @(posedge i_clk);
    model_update(p, s, t);
    @(negedge i_clk);
    i_btn_power = 1'b0;
    i_btn_speed = 1'b0;
    i_btn_timer = 1'b0;
  endtask

  task automatic test_reset();
    i_reset     = 1'b1;
    i_btn_power = 1'b0;
    i_btn_speed = 1'b0;
    i_btn_timer = 1'b0;
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    total++;
    if ({o_fanState, o_pwm, o_timer_active, o_timer_remain} !== 12'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got state=%0d pwm=%0d act=%0d rem=%0d, expected all 0",
               o_fanState, o_pwm, o_timer_active, o_timer_remain);
    end
    i_reset = 1'b0;
    drive_cycle(0, 0, 0);
    total++;
    if (o_fanState !== 3'd0 || o_pwm !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got state=%0d pwm=%0d, expected 0 0", o_fanState, o_pwm);
    end
  endtask

  task automatic test_speed_cycle();
    int exp_seq[4] = '{1, 2, 3, 1};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_cycle(1, 0, 0);
      else        drive_cycle(0, 1, 0);
      total++;
      if (o_fanState !== 3'(exp_seq[i])) begin
        bad++;
        $display("[TB] FAIL speed_step%0d: got %0d expected %0d", i, o_fanState, exp_seq[i]);
      end
    end
  endtask

  task automatic test_pwm();
    int highs;
    int exp_highs[3] = '{3, 9, 0};
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        drive_cycle(0, 1, 0);
        drive_cycle(0, 1, 0);
      end else if (k == 2) begin
        drive_cycle(1, 0, 0);
      end
      highs = 0;
      for (int i = 0; i < 10; i++) begin
        drive_cycle(0, 0, 0);
        if (o_pwm === 1'b1) highs++;
      end
      total++;
      if (highs != exp_highs[k]) begin
        bad++;
        $display("[TB] FAIL pwm_highs%0d: got %0d expected %0d", k, highs, exp_highs[k]);
      end
    end
  endtask

  task automatic test_off_ignore();
    logic [2:0] pat[3] = '{3'b010, 3'b001, 3'b011};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(pat[i][2], pat[i][1], pat[i][0]);
      total++;
      if (o_fanState !== 3'd0 || o_timer_remain !== 7'd0 || o_timer_active !== 1'b0) begin
        bad++;
        $display("[TB] FAIL off_ignore%0d: got state=%0d rem=%0d act=%0d, expected 0 0 0",
                 i, o_fanState, o_timer_remain, o_timer_active);
      end
    end
  endtask

  task automatic test_timer_countdown();
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 0);
    drive_cycle(0, 0, 1);
    total++;
    if (o_timer_remain !== 7'd2 || o_timer_active !== 1'b1 || o_fanState !== 3'd2) begin
      bad++;
      $display("[TB] FAIL countdown_press: got rem=%0d act=%0d state=%0d, expected 2 1 2",
               o_timer_remain, o_timer_active, o_fanState);
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 0, 0);
      if (i == 8 || i == 9 || i == 18) begin
        total++;
        if (o_timer_remain !== 7'(m_remain) || o_timer_active !== 1'b1 || o_fanState !== 3'd2) begin
          bad++;
          $display("[TB] FAIL countdown_c%0d: got rem=%0d act=%0d state=%0d, expected %0d 1 2",
                   i + 1, o_timer_remain, o_timer_active, o_fanState, m_remain);
        end
      end
    end
    total++;
    if (o_timer_remain !== 7'd0 || o_timer_active !== 1'b0 || o_fanState !== 3'd0) begin
      bad++;
      $display("[TB] FAIL countdown_expire: got rem=%0d act=%0d state=%0d, expected 0 0 0",
               o_timer_remain, o_timer_active, o_fanState);
    end
  endtask

  task automatic test_timer_steps();
    int exp_rem[4] = '{2, 4, 6, 0};
    drive_cycle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 0, 1);
      total++;
      if (o_timer_remain !== 7'(exp_rem[i]) || o_timer_active !== (exp_rem[i] != 0)) begin
        bad++;
        $display("[TB] FAIL timer_step%0d: got rem=%0d act=%0d, expected %0d %0d",
                 i, o_timer_remain, o_timer_active, exp_rem[i], exp_rem[i] != 0);
      end
    end
    drive_cycle(0, 0, 1);
    drive_cycle(1, 1, 0);
    total++;
    if (o_fanState !== 3'd0 || o_timer_remain !== 7'd0 || o_timer_active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL power_speed_same: got state=%0d rem=%0d act=%0d, expected 0 0 0",
               o_fanState, o_timer_remain, o_timer_active);
    end
  endtask

  task automatic test_expiry_press();
    drive_cycle(1, 0, 0);
    drive_cycle(0, 0, 1);
    for (int i = 0; i < 19; i++) drive_cycle(0, 0, 0);
    total++;
    if (o_timer_remain !== 7'd1 || o_fanState !== 3'd1) begin
      bad++;
      $display("[TB] FAIL expiry_pre: got rem=%0d state=%0d, expected 1 1", o_timer_remain, o_fanState);
    end
    drive_cycle(0, 1, 1);
    total++;
    if (o_fanState !== 3'd0 || o_timer_remain !== 7'd0 || o_timer_active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL expiry_press: got state=%0d rem=%0d act=%0d, expected 0 0 0",
               o_fanState, o_timer_remain, o_timer_active);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0);
    drive_cycle(0, 1, 0);
    drive_cycle(0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      if (m_pwm_pos < duty_tab[m_level] && m_cyc_left < 8) break;
      drive_cycle(0, 0, 0);
    end
    total++;
    if (o_pwm !== 1'b1 || o_timer_active !== 1'b1) begin
      bad++;
      $display("[TB] FAIL async_pre: got pwm=%0d act=%0d, expected 1 1", o_pwm, o_timer_active);
    end
    #2 i_reset = 1'b1;
    #1;
    total++;
    if ({o_fanState, o_pwm, o_timer_active, o_timer_remain} !== 12'd0) begin
      bad++;
      $display("[TB] FAIL async_reset: got state=%0d pwm=%0d act=%0d rem=%0d, expected all 0",
               o_fanState, o_pwm, o_timer_active, o_timer_remain);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    model_reset();
    drive_cycle(1, 0, 0);
    total++;
    if (o_fanState !== 3'd1 || o_timer_remain !== 7'd0) begin
      bad++;
      $display("[TB] FAIL post_reset_power: got state=%0d rem=%0d, expected 1 0", o_fanState, o_timer_remain);
    end
  endtask

  task automatic test_random();
    logic p, s, t;
    logic exp_pwm;
    for (int i = 0; i < 3000; i++) begin
      p = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 5) == 0);
      t = ($urandom_range(0, 24) == 0);
      drive_cycle(p, s, t);
      exp_pwm = (m_pwm_pos < duty_tab[m_level]);
      total++;
      if (o_fanState !== 3'(m_level) || o_timer_remain !== 7'(m_remain) ||
          o_timer_active !== (m_remain != 0) || o_pwm !== exp_pwm) begin
        bad++;
        $display("[TB] FAIL random_c%0d: got state=%0d rem=%0d act=%0d pwm=%0d, expected %0d %0d %0d %0d",
                 i, o_fanState, o_timer_remain, o_timer_active, o_pwm,
                 m_level, m_remain, m_remain != 0, exp_pwm);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_speed_cycle();
    test_pwm();
    test_off_ignore();
    test_timer_countdown();
    test_timer_steps();
    test_expiry_press();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fan_state_ctrl.md
FAN_STATE_CTRL -- requirements
Module: fan_state_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100000000: clock cycles per 1 s timer tick.
REQ-002 SHALL have parameter PWM_PERIOD, default 100: PWM counter period in clock cycles.
REQ-003 SHALL have parameters DUTY_LOW, DUTY_MID, DUTY_HIGH, defaults 30, 60, 90: PWM high-cycles per period for each speed.
REQ-004 SHALL have parameter TIMER_STEP, default 30: seconds added per timer press.
REQ-005 SHALL have port i_clk, input, 1: single system clock, rising edge.
REQ-006 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_btn_power, input, 1: one-cycle pulse that toggles the fan on or off.
REQ-008 SHALL have port i_btn_speed, input, 1: one-cycle pulse that advances the speed.
REQ-009 SHALL have port i_btn_timer, input, 1: one-cycle pulse that steps the auto-off timer.
REQ-010 SHALL have port o_fanState, output, 3: 0=OFF, 1=LOW, 2=MID, 3=HIGH; drives the FND value decoder directly.
REQ-011 SHALL have port o_pwm, output, 1: fan motor PWM.
REQ-012 SHALL have port o_timer_active, output, 1: auto-off countdown armed.
REQ-013 SHALL have port o_timer_remain, output, 7: remaining seconds, 0..3*TIMER_STEP.

Function
REQ-014 Button inputs SHALL be treated as already debounced, synchronous one-cycle pulses.
REQ-015 The FSM SHALL have states OFF, LOW, MID, HIGH, encoded on o_fanState as 0..3; values 4..7 SHALL never be driven.
REQ-016 A power pulse SHALL move OFF->LOW and any of LOW/MID/HIGH->OFF.
REQ-017 A speed pulse SHALL move LOW->MID->HIGH->LOW (wrap) and SHALL be ignored in OFF.
REQ-018 A timer pulse SHALL step the remaining time 0->TIMER_STEP->2*TIMER_STEP->3*TIMER_STEP->0 and SHALL be ignored in OFF.
REQ-019 Stepping to nonzero SHALL set o_timer_active=1; stepping to 0 SHALL clear it.
REQ-020 Each timer press SHALL restart the tick prescaler, so the first decrement occurs exactly TICK_CYCLES cycles after the press.
REQ-021 While active, o_timer_remain SHALL decrement by 1 on each tick.
REQ-022 When a tick takes o_timer_remain from 1 to 0, the next state SHALL be OFF and o_timer_active SHALL be 0.
REQ-023 Entering OFF by any cause SHALL clear o_timer_remain and o_timer_active in the same cycle.
REQ-024 All state changes SHALL be registered and visible one clock after the pulse or tick cycle.
REQ-025 Priority within one cycle SHALL be: power > timer expiry > speed and timer press; speed and timer presses in the same cycle SHALL both take effect.
REQ-026 A timer press in the same cycle as an expiry tick SHALL be ignored, and the fan SHALL go to OFF.
REQ-027 The PWM counter SHALL run freely from 0 to PWM_PERIOD-1 and wrap, independent of state.
REQ-028 o_pwm SHALL be 1 iff counter < duty, with duty 0 in OFF and DUTY_LOW, DUTY_MID or DUTY_HIGH per speed; the new duty SHALL apply from the cycle after the state change.
REQ-029 The prescaler SHALL count only while the timer is active and SHALL hold at 0 otherwise.

Reset
REQ-030 Asserting i_reset SHALL, asynchronously, force o_fanState=0, o_pwm=0, o_timer_active=0, o_timer_remain=0, and reset the PWM counter and prescaler to 0.
REQ-031 After i_reset deasserts, button pulses SHALL be honoured from the first rising edge; reset mid-countdown SHALL discard the timer.

Verification (TICK_CYCLES=10, PWM_PERIOD=10, DUTY 3/6/9, TIMER_STEP=2)
REQ-032 SHALL cover: power pulse, then 3 speed pulses -> o_fanState 1, 2, 3, 1, each one cycle after its pulse.
REQ-033 SHALL cover: in LOW, count o_pwm highs over one period -> 3; in HIGH -> 9; in OFF -> 0.
REQ-034 SHALL cover: speed and timer pulses while OFF -> o_fanState stays 0 and o_timer_remain stays 0.
REQ-035 SHALL cover: in MID, one timer press -> remain=2, remain=1 after 10 cycles, remain=0 and o_fanState=0 after 20 cycles.
REQ-036 SHALL cover: four timer presses -> remain 2, 4, 6, 0 and active 1, 1, 1, 0; power and speed in the same cycle -> OFF.
REQ-037 SHALL cover: i_reset asserted mid-countdown between clock edges -> all outputs are 0 immediately, before the next edge.
